// File: rtl/obstacle_layer_engine.sv
// obstacle_layer_engine: NUM_OBJ scrolling obstacle slots sharing one sprite bitmap,
// rendered into a registered pixel layer, with a sticky player collision flag.
module obstacle_layer_engine #(
   parameter int          NUM_OBJ   = 4,
   parameter int          SPR_W     = 16,
   parameter int          SPR_H     = 16,
   parameter int          H_ACTIVE  = 640,
   parameter int          Y_BASE    = 96,
   parameter int          Y_STEP    = 96,
   parameter int          MIN_GAP   = 20,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_start,
   input  logic [9:0]         haddress,
   input  logic [9:0]         vaddress,
   input  logic               player_pixel,
   input  logic               run,
   input  logic               clear_collide,
   input  logic [3:0]         speed,
   input  logic               bmp_we,
   input  logic [4:0]         bmp_row,
   input  logic [SPR_W-1:0]   bmp_data,
   output logic               obj_pixel,
   output logic               collide,
   output logic [NUM_OBJ-1:0] obj_active,
   output logic [15:0]        spawn_count
);
   localparam int RW = SPR_H > 1 ? $clog2(SPR_H) : 1;
   localparam int CW = SPR_W > 1 ? $clog2(SPR_W) : 1;
   localparam int IW = NUM_OBJ > 1 ? $clog2(NUM_OBJ) : 1;
   logic [SPR_W-1:0]   bmp [SPR_H];
   logic [10:0]        x [NUM_OBJ];
   logic [10:0]        y [NUM_OBJ];
   logic [15:0]        lfsr;
   logic [15:0]        timer;
   logic [NUM_OBJ-1:0] hit_pix;
   logic [IW-1:0]      free_idx;
   logic               pp_d;
   logic               upd;
   logic               in_vis;
   assign upd    = frame_start && run && !collide;
   assign in_vis = {1'b0, haddress} < 11'(H_ACTIVE) && vaddress < 10'd480;
   // Lowest-index slot that was free before this frame's moves.
   always_comb begin
      free_idx = '0;
      for (int i = NUM_OBJ - 1; i >= 0; i--)
         if (!obj_active[i]) free_idx = IW'(i);
   end
   // 11-bit offsets keep x up to H_ACTIVE+SPR_W from wrapping.
   for (genvar k = 0; k < NUM_OBJ; k++) begin : g_slot
      logic [10:0] dh, dv;
      assign dh = {1'b0, haddress} - x[k];
      assign dv = {1'b0, vaddress} - y[k];
      assign hit_pix[k] = obj_active[k] && {1'b0, haddress} >= x[k] && dh < 11'(SPR_W) &&
                          {1'b0, vaddress} >= y[k] && dv < 11'(SPR_H) && bmp[dv[RW-1:0]][dh[CW-1:0]];
   end
   always_ff @(posedge clk) begin
      if (bmp_we && 32'(bmp_row) < SPR_H) bmp[bmp_row[RW-1:0]] <= bmp_data;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lfsr      <= LFSR_SEED;
         pp_d      <= 1'b0;
         obj_pixel <= 1'b0;
      end else begin
         lfsr      <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
         pp_d      <= player_pixel;
         obj_pixel <= in_vis && |hit_pix;
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         obj_active  <= '0;
         timer       <= 16'(MIN_GAP);
         spawn_count <= '0;
         collide     <= 1'b0;
         for (int i = 0; i < NUM_OBJ; i++) begin
            x[i] <= '0;
            y[i] <= '0;
         end
      end else if (clear_collide) begin
         obj_active  <= '0;
         timer       <= 16'(MIN_GAP);
         spawn_count <= '0;
         collide     <= 1'b0;
      end else begin
         if (obj_pixel && pp_d) collide <= 1'b1;
         if (upd) begin
            for (int i = 0; i < NUM_OBJ; i++)
               if (obj_active[i]) begin
                  if (x[i] < 11'(speed)) obj_active[i] <= 1'b0;
                  else x[i] <= x[i] - 11'(speed);
               end
            if (timer != '0) timer <= timer - 16'd1;
            else if (!(&obj_active)) begin
               obj_active[free_idx] <= 1'b1;
               x[free_idx]          <= 11'(H_ACTIVE);
               y[free_idx]          <= 11'(Y_BASE) + 11'(lfsr[1:0]) * 11'(Y_STEP);
               timer                <= 16'(MIN_GAP) + 16'(lfsr[5:2]);
               spawn_count          <= spawn_count + 16'(spawn_count != 16'hFFFF);
            end
         end
      end
   end
endmodule

// File: tb/tb_obstacle_layer_engine.sv
// tb_obstacle_layer_engine: directed scenarios plus randomized traffic, every cycle
// compared against a frame/pixel-level reference model of the obstacle layer.
module tb_obstacle_layer_engine;
   localparam int N = 4, SW = 16, SH = 16, HA = 640, YB = 96, YS = 96, GAP = 20;
   logic          clk = 1'b0, reset = 1'b0, frame_start = 1'b0, player_pixel = 1'b0;
   logic          run = 1'b0, clear_collide = 1'b0, bmp_we = 1'b0;
   logic [9:0]    haddress = 10'd700, vaddress = 10'd0;
   logic [3:0]    speed = 4'd0;
   logic [4:0]    bmp_row = 5'd0;
   logic [SW-1:0] bmp_data = '0;
   logic          obj_pixel, collide;
   logic [N-1:0]  obj_active;
   logic [15:0]   spawn_count;
   int checks = 0, errors = 0;
   bit [N-1:0]  m_act;
   int          m_x [N];
   int          m_y [N];
   int          m_timer, m_cnt;
   bit          m_col, m_pix, m_ppd;
   bit [15:0]   m_lfsr;
   bit [SW-1:0] m_bmp [SH];

   obstacle_layer_engine dut (
      .clk(clk), .reset(reset), .frame_start(frame_start), .haddress(haddress),
      .vaddress(vaddress), .player_pixel(player_pixel), .run(run),
      .clear_collide(clear_collide), .speed(speed), .bmp_we(bmp_we), .bmp_row(bmp_row),
      .bmp_data(bmp_data), .obj_pixel(obj_pixel), .collide(collide),
      .obj_active(obj_active), .spawn_count(spawn_count));

   always #5 clk = ~clk;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic m_reset();
      m_act = '0; m_timer = GAP; m_cnt = 0; m_col = 0; m_pix = 0; m_ppd = 0; m_lfsr = 16'hACE1;
      for (int k = 0; k < N; k++) begin m_x[k] = 0; m_y[k] = 0; end
   endtask

   task automatic m_step();
      bit pix, upd;
      int h, v, fr;
      h = int'(haddress); v = int'(vaddress); pix = 0;
      if (h < HA && v < 480)
         for (int k = 0; k < N; k++)
            if (m_act[k] && h >= m_x[k] && h < m_x[k] + SW && v >= m_y[k] && v < m_y[k] + SH)
               pix |= m_bmp[v - m_y[k]][h - m_x[k]];
      upd = frame_start && run && !m_col && !clear_collide;
      if (clear_collide) begin
         m_col = 0; m_act = '0; m_timer = GAP; m_cnt = 0;
      end else if (m_pix && m_ppd) m_col = 1;
      if (upd) begin
         fr = -1;
         for (int k = N - 1; k >= 0; k--) if (!m_act[k]) fr = k;
         for (int k = 0; k < N; k++)
            if (m_act[k]) begin
               if (m_x[k] < int'(speed)) m_act[k] = 0;
               else m_x[k] -= int'(speed);
            end
         if (m_timer > 0) m_timer--;
         else if (fr >= 0) begin
            m_act[fr] = 1; m_x[fr] = HA; m_y[fr] = YB + int'(m_lfsr % 4) * YS;
            m_timer = GAP + int'((m_lfsr >> 2) % 16);
            if (m_cnt < 65535) m_cnt++;
         end
      end
      m_pix = pix; m_ppd = player_pixel;
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      if (bmp_we && int'(bmp_row) < SH) m_bmp[bmp_row] = bmp_data;
   endtask

   always @(posedge clk or negedge reset)
      if (!reset) m_reset(); else m_step();

   task automatic tick();
      @(negedge clk);
      check("active", 32'(obj_active), 32'(m_act));
      check("count", 32'(spawn_count), 32'(m_cnt));
      check("collide", 32'(collide), 32'(m_col));
      check("pixel", 32'(obj_pixel), 32'(m_pix));
   endtask

   task automatic frame(int s);
      frame_start = 1'b1; speed = 4'(s); tick();
      frame_start = 1'b0; tick();
   endtask

   task automatic probe(int h, int v, bit exp, string tag);
      haddress = 10'(h); vaddress = 10'(v); tick();
      check(tag, 32'(obj_pixel), 32'(exp));
      haddress = 10'd700;
   endtask

   task automatic steer(int k, int target);
      int n = 0;
      while (m_act[k] && m_x[k] > target && n < 200) begin
         frame(m_x[k] - target > 15 ? 15 : m_x[k] - target);
         n++;
      end
      check("steer_bound", 32'(n < 200), 1);
      check("steer_alive", 32'(obj_active[k]), 1);
   endtask

   initial begin
      int n, c0, y0, h0;
      m_reset();
      tick(); tick();
      reset = 1'b1;
      check("rst_active", 32'(obj_active), 0);
      check("rst_collide", 32'(collide), 0);
      check("rst_count", 32'(spawn_count), 0);
      check("rst_pixel", 32'(obj_pixel), 0);
      for (int r = 0; r < SH; r++) begin
         bmp_we = 1'b1; bmp_row = 5'(r); bmp_data = '1; tick();
      end
      bmp_we = 1'b0;
      // First spawn waits MIN_GAP frames
      run = 1'b1;
      for (int i = 0; i < 20; i++) frame(4);
      check("pre_spawn_active", 32'(obj_active), 0);
      check("pre_spawn_count", 32'(spawn_count), 0);
      frame(4);
      check("spawn_active", 32'(obj_active), 1);
      check("spawn_count1", 32'(spawn_count), 1);
      for (int i = 0; i < 4; i++) frame(4);
      // Sprite rectangle at x=100
      steer(0, 100);
      run = 1'b0; y0 = m_y[0];
      foreach (m_x[i]) ;
      for (int dv = -1; dv <= 16; dv += 1)
         if (dv == -1 || dv == 0 || dv == 15 || dv == 16)
            for (int h = 98; h <= 117; h++)
               probe(h, y0 + dv, h >= 100 && h <= 115 && dv >= 0 && dv <= 15, "rect");
      run = 1'b1;
      // x < speed retires, x == speed lands on 0
      steer(0, 3);
      frame(4);
      check("x3_retired", 32'(obj_active[0]), 0);
      n = 0;
      while (!m_act[0] && n < 100) begin frame(0); n++; end
      check("respawn_bound", 32'(n < 100), 1);
      steer(0, 4);
      frame(4);
      check("x4_alive", 32'(obj_active[0]), 1);
      probe(0, m_y[0], 1, "x0_pixel");
      // Make slot 2 the oldest, fill all slots, then free only slot 2
      clear_collide = 1'b1; tick(); clear_collide = 1'b0;
      n = 0;
      while (m_act[1:0] != 2'b11 && n < 100) begin frame(0); n++; end
      while (!m_act[2] && n < 200) begin frame(15); n++; end
      while (m_act[0] && n < 300) begin frame(15); n++; end
      while (m_act != 4'hF && n < 500) begin frame(0); n++; end
      check("fill_bound", 32'(n < 500), 1);
      c0 = m_cnt;
      for (int i = 0; i < 40; i++) frame(0);
      check("full_count", 32'(spawn_count), 32'(c0));
      check("full_active", 32'(obj_active), 32'hF);
      n = 0;
      while (m_x[2] >= 15 && n < 100) begin frame(15); n++; end
      frame(m_x[2] + 1);
      check("free2", 32'(obj_active), 32'hB);
      frame(0);
      check("respawn2", 32'(obj_active), 32'hF);
      check("respawn2_count", 32'(spawn_count), 32'(c0 + 1));
      // Collision freezes the scene
      for (int i = 0; i < 3; i++) frame(15);
      h0 = m_x[2]; y0 = m_y[2];
      haddress = 10'(h0); vaddress = 10'(y0); player_pixel = 1'b1; tick();
      check("hit_pixel", 32'(obj_pixel), 1);
      player_pixel = 1'b0; haddress = 10'd700; tick();
      check("collide_set", 32'(collide), 1);
      c0 = m_cnt;
      for (int i = 0; i < 3; i++) frame(15);
      probe(h0, y0, 1, "frozen_pixel");
      check("frozen_count", 32'(spawn_count), 32'(c0));
      haddress = 10'(h0); vaddress = 10'(y0); player_pixel = 1'b1; tick();
      clear_collide = 1'b1; player_pixel = 1'b0; haddress = 10'd700; tick();
      clear_collide = 1'b0;
      check("clr_collide", 32'(collide), 0);
      check("clr_active", 32'(obj_active), 0);
      check("clr_count", 32'(spawn_count), 0);
      // Bitmap row write 8001 at x=200
      for (int i = 0; i < 21; i++) frame(4);
      check("regen_active", 32'(obj_active[0]), 1);
      steer(0, 200);
      run = 1'b0;
      bmp_we = 1'b1; bmp_row = 5'd0; bmp_data = 16'h8001; tick();
      bmp_row = 5'd17; bmp_data = 16'h0000; tick();
      bmp_we = 1'b0; y0 = m_y[0];
      for (int h = 198; h <= 217; h++) probe(h, y0, h == 200 || h == 215, "row8001");
      probe(201, y0 + 1, 1, "row1_kept");
      // Randomized traffic with a mid-run asynchronous reset
      run = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 1) == 0) begin
            int k, h, v;
            k = $urandom_range(0, N - 1);
            h = m_x[k] + int'($urandom_range(0, 19)) - 2;
            v = m_y[k] + int'($urandom_range(0, 19)) - 2;
            haddress = 10'(h < 0 ? 0 : h); vaddress = 10'(v < 0 ? 0 : v);
         end else begin
            haddress = 10'($urandom_range(0, 700)); vaddress = 10'($urandom_range(0, 520));
         end
         player_pixel  = $urandom_range(0, 3) == 0;
         clear_collide = $urandom_range(0, 149) == 0;
         frame_start   = $urandom_range(0, 3) == 0;
         run           = $urandom_range(0, 9) != 0;
         speed         = 4'($urandom_range(0, 15));
         bmp_we        = $urandom_range(0, 19) == 0;
         bmp_row       = 5'($urandom_range(0, 19));
         bmp_data      = 16'($urandom);
         tick();
         if (i == 2000) begin
            #2 reset = 1'b0;
            #1;
            check("async_active", 32'(obj_active), 0);
            check("async_pixel", 32'(obj_pixel), 0);
            check("async_count", 32'(spawn_count), 0);
            tick(); tick();
            reset = 1'b1;
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
endmodule

// File: doc/obstacle_layer_engine.md
Name: obstacle_layer_engine

Overview:
- Parametrised obstacle generator and renderer for the VGA game datapath, replacing hand-placed fixed sprites with NUM_OBJ scrolling object slots.
- Runs on the 25 MHz pixel clock. It spawns objects at pseudo-random lanes, scrolls them left once per frame, and renders one shared bitmap per slot into a single obstacle pixel layer.
- Detects player/obstacle overlap and raises a sticky collide flag that is consumed by the game-state FSM and the score/movement blocks.

Parameters:
- NUM_OBJ, 4: number of object slots (1..8).
- SPR_W, 16: sprite width in pixels (≤32).
- SPR_H, 16: sprite height in pixels (≤32).
- H_ACTIVE, 640: visible columns; also the spawn x position.
- Y_BASE, 96: y of lane 0.
- Y_STEP, 96: vertical distance between lanes (4 lanes).
- MIN_GAP, 20: minimum number of frames between spawns.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous reset, active-low
- frame_start  in  1  one-cycle pulse at start of vertical blank
- haddress  in  10  current scan column
- vaddress  in  10  current scan row
- player_pixel  in  1  player layer pixel for the same haddress/vaddress
- run  in  1  1 = game running; scrolling and spawning enabled
- clear_collide  in  1  clears collide and all slots (restart)
- speed  in  4  pixels moved per frame
- bmp_we  in  1  bitmap row write enable
- bmp_row  in  5  bitmap row address
- bmp_data  in  SPR_W  bitmap row data; bit i = column i
- obj_pixel  out  1  obstacle layer pixel, 1-cycle latency
- collide  out  1  sticky collision flag
- obj_active  out  NUM_OBJ  per-slot active flags
- spawn_count  out  16  number of spawns since reset or clear, saturating

Behaviour:
- Reset (asynchronous, reset=0): all slots inactive, x=0, y=0; obj_pixel=0, collide=0, spawn_count=0; LFSR=LFSR_SEED; spawn timer=MIN_GAP. The bitmap is not reset.
- LFSR: 16-bit Galois, taps 16,14,13,11. Advances every clk cycle regardless of run.
- Bitmap: SPR_H x SPR_W storage. On bmp_we, the row at bmp_row is written at the clock edge. bmp_row ≥ SPR_H is ignored. A written row is readable by the render path on the next cycle.
- Frame update happens only in a cycle where frame_start=1 && run=1 && collide=0:
  - Every active slot: if x < speed, slot goes inactive; else x ← x − speed.
  - Spawn timer: if non-zero, decrements. If zero, the lowest-index inactive slot gets active=1, x=H_ACTIVE, y=Y_BASE + LFSR[1:0]*Y_STEP; the timer reloads with MIN_GAP + LFSR[5:2]; spawn_count increments, saturating at 16'hFFFF.
  - If the timer is zero and no slot is inactive, no spawn occurs and the timer stays 0, so the spawn is retried next frame.
  - Move and spawn are evaluated in the same frame. A slot freed in this frame is not reusable until the next frame.
- Render:
  - Slot k hits when active, x ≤ haddress < x+SPR_W, and y ≤ vaddress < y+SPR_H.
  - Pixel value is bitmap[vaddress−y][haddress−x].
  - obj_pixel is registered: it equals the OR over all slots of the hit pixel for the haddress/vaddress presented one cycle earlier.
  - If haddress ≥ H_ACTIVE or vaddress ≥ 480, obj_pixel=0.
  - Width rule: subtraction and comparison use 11-bit unsigned arithmetic, so x up to H_ACTIVE+SPR_W never wraps.
- Collision:
  - player_pixel is delayed internally by one cycle to align with obj_pixel.
  - collide ← 1 on the cycle after obj_pixel=1 && player_pixel_delayed=1.
  - Once set, collide freezes all scrolling and spawning; render continues so the frozen scene stays visible.
  - clear_collide=1 in a cycle: collide←0, all slots inactive, spawn timer←MIN_GAP, spawn_count←0. clear_collide takes priority over a simultaneous collision set and over a frame update in that same cycle.
- run=0: slots hold position and are still rendered; collide detection stays active.
- Reset asserted mid-frame: all state clears immediately; obj_pixel=0 until two cycles after deassertion.

Test Plan:
- Reset, then run=1, speed=4, 25 frame_start pulses: no spawn until frame 21; then obj_active=0001, slot0 x=640, spawn_count=1.
- Slot0 active at x=100, y=96, bitmap all-ones: obj_pixel=1 exactly for h∈[100,115], v∈[96,111], one cycle after the address is presented; 0 at h=99 and h=116.
- Slot at x=3, speed=4, frame_start: slot goes inactive. With x=4: x becomes 0 and the slot stays active.
- All NUM_OBJ slots active and the spawn timer expires: no spawn, spawn_count unchanged, timer=0. Free slot 2: next frame spawns into slot 2.
- player_pixel=1 aligned with an obj_pixel=1 pixel: collide=1 next cycle. Further frame_start pulses leave all x unchanged. clear_collide and a collision in the same cycle: collide=0 and obj_active=0.
- Write bitmap row 0 = 16'h8001 with bmp_we; render row 0 of a slot at x=200: obj_pixel=1 only at h=200 and h=215.
